// File: rtl/io_ports.sv
// io_ports: parametrised multi-port parallel I/O block.
//
// Provides NPORTS bidirectional ports of WIDTH bits each. Every port has a
// data register, a data-direction register, and edge-triggered pin
// interrupts with selectable polarity, an enable mask and sticky flags.
// Pin inputs go through SYNC_STAGES synchroniser flops before any use.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   enable       register select, one access per cycle while high
//   we_n         0 = write, 1 = read
//   A            {port index, register[2:0]}
//   DI / DO      write data / registered read data
//   OE           high for exactly the cycle DO carries valid read data
//   PO, DDR      port output latches and pad direction (1 = output)
//   PI           raw asynchronous pin inputs
//   IRQ_n        active-low interrupt, low while any (IFR & IEN) bit is set
//
// Bus handshake: a request is presented by holding enable high for one
// cycle; there is no stall. Writes take effect at that edge. Reads return
// DO together with OE = 1 in the following cycle; OE is the only qualifier
// of DO, and DO is forced to 0 whenever OE is 0. Reads of a port index
// beyond NPORTS return nothing (OE stays 0).
//
// Register map per port (A[2:0]):
//   0 DATA  write loads PO; read returns DDR ? PO : synchronised PI
//   1 DDR   2 IEN   3 IFR (write-1-to-clear)   4 EDGE (1 = rising)
//   5-7     reserved: writes ignored, reads return 0
module io_ports #(
  parameter int NPORTS      = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = $clog2(NPORTS) + 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    we_n,
  input  logic [AW-1:0]           A,
  input  logic [WIDTH-1:0]        DI,
  output logic [WIDTH-1:0]        DO,
  output logic                    OE,
  output logic [NPORTS*WIDTH-1:0] PO,
  input  logic [NPORTS*WIDTH-1:0] PI,
  output logic [NPORTS*WIDTH-1:0] DDR,
  output logic                    IRQ_n
);

  localparam int NW = NPORTS * WIDTH;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_DONE = CW'(SYNC_STAGES + 1);

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_DDR  = 3'd1;
  localparam logic [2:0] REG_IEN  = 3'd2;
  localparam logic [2:0] REG_IFR  = 3'd3;
  localparam logic [2:0] REG_EDGE = 3'd4;

  logic [NW-1:0] po_q, ddr_q, ien_q, ifr_q, edge_q;
  logic [NW-1:0] sync_q [SYNC_STAGES];
  logic [NW-1:0] hist_q;
  logic [NW-1:0] pin_s, rise, fall, evt, clr;
  logic [CW-1:0] arm_cnt;
  logic          armed;
  logic [31:0]   port_idx;
  logic [2:0]    reg_sel;
  logic          port_ok, wr, rd;
  logic [WIDTH-1:0] rd_data;

  // Port index is the address above the 3 register bits; with a single
  // port there are no such bits and the shift simply yields 0.
  assign port_idx = 32'(A >> 3);
  assign reg_sel  = A[2:0];
  assign port_ok  = port_idx < 32'(NPORTS);
  assign wr       = enable & ~we_n & port_ok;
  assign rd       = enable & we_n;

  // Pin synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= PI;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];
  assign rise  = pin_s & ~hist_q;
  assign fall  = ~pin_s & hist_q;

  // Flags stay suppressed until the chain and history flop hold real pin
  // data; otherwise a pin held high through reset looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + CW'(1);
  end
  assign armed = (arm_cnt == ARM_DONE);

  // Registered DDR/EDGE are used here, so a same-cycle write to either
  // only affects detection from the next cycle on.
  assign evt = armed ? (~ddr_q & ((edge_q & rise) | (~edge_q & fall))) : '0;

  always_comb begin
    clr = '0;
    for (int p = 0; p < NPORTS; p++)
      if (wr && reg_sel == REG_IFR && port_idx == 32'(p))
        clr[p*WIDTH +: WIDTH] = DI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_q   <= '0;
      ddr_q  <= '0;
      ien_q  <= '0;
      ifr_q  <= '0;
      edge_q <= '0;
    end else begin
      // Set is OR'ed after the clear so a simultaneous event wins.
      ifr_q <= (ifr_q & ~clr) | evt;
      for (int p = 0; p < NPORTS; p++) begin
        if (wr && port_idx == 32'(p)) begin
          case (reg_sel)
            REG_DATA: po_q[p*WIDTH +: WIDTH]   <= DI;
            REG_DDR:  ddr_q[p*WIDTH +: WIDTH]  <= DI;
            REG_IEN:  ien_q[p*WIDTH +: WIDTH]  <= DI;
            REG_EDGE: edge_q[p*WIDTH +: WIDTH] <= DI;
            default:  ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_idx == 32'(p)) begin
        case (reg_sel)
          REG_DATA: rd_data = (ddr_q[p*WIDTH +: WIDTH] & po_q[p*WIDTH +: WIDTH]) |
                              (~ddr_q[p*WIDTH +: WIDTH] & pin_s[p*WIDTH +: WIDTH]);
          REG_DDR:  rd_data = ddr_q[p*WIDTH +: WIDTH];
          REG_IEN:  rd_data = ien_q[p*WIDTH +: WIDTH];
          REG_IFR:  rd_data = ifr_q[p*WIDTH +: WIDTH];
          REG_EDGE: rd_data = edge_q[p*WIDTH +: WIDTH];
          default:  rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DO <= '0;
      OE <= 1'b0;
    end else begin
      DO <= (rd && port_ok) ? rd_data : '0;
      OE <= rd && port_ok;
    end
  end

  assign PO    = po_q;
  assign DDR   = ddr_q;
  assign IRQ_n = ~|(ifr_q & ien_q);

endmodule

// File: tb/tb_io_ports.sv
// tb_io_ports: directed self-checking bench for io_ports, built with three
// ports so that an out-of-range port index (3) is addressable.
module tb_io_ports;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int AW = $clog2(NP) + 3;
  localparam int NW = NP * W;

  logic          clk, rst_n, enable, we_n;
  logic [AW-1:0] A;
  logic [W-1:0]  DI, DO;
  logic          OE, IRQ_n;
  logic [NW-1:0] PO, PI, DDR;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] rdata;
  logic         roe;

  io_ports #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .we_n(we_n), .A(A),
    .DI(DI), .DO(DO), .OE(OE), .PO(PO), .PI(PI), .DDR(DDR), .IRQ_n(IRQ_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers: each access spans exactly one rising edge; results sampled at
  // the falling edge that follows it
  task automatic bus_write(input int port, input int rsel, input logic [W-1:0] data);
    @(negedge clk);
    enable = 1'b1; we_n = 1'b0; A = AW'(port * 8 + rsel); DI = data;
    @(negedge clk);
    enable = 1'b0; we_n = 1'b1;
  endtask

  task automatic bus_read(input int port, input int rsel, output logic [W-1:0] data,
                          output logic oe);
    @(negedge clk);
    enable = 1'b1; we_n = 1'b1; A = AW'(port * 8 + rsel);
    @(negedge clk);
    enable = 1'b0;
    data = DO;
    oe   = OE;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; we_n = 1'b1; A = '0; DI = '0;
    PI = 24'h00003C;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_po",  32'(PO), 32'h0);
    check("rst_ddr", 32'(DDR), 32'h0);
    check("rst_do",  32'(DO), 32'h0);
    check("rst_oe",  32'(OE), 32'h0);
    check("rst_irq", 32'(IRQ_n), 32'h1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // DDR / DATA / mixed read
    bus_write(0, 1, 8'hF0);
    check("ddr0", 32'(DDR), 32'h0000F0);
    bus_write(0, 0, 8'hA5);
    check("po0", 32'(PO), 32'h0000A5);
    bus_read(0, 0, rdata, roe);
    check("data0_do", 32'(rdata), 32'hAC);
    check("data0_oe", 32'(roe), 32'h1);
    @(negedge clk);
    check("oe_drop", 32'(OE), 32'h0);
    check("do_idle", 32'(DO), 32'h0);

    // rising-edge interrupt on port 1 bit 0, latency 3 edges
    bus_write(1, 4, 8'h01);
    bus_write(1, 2, 8'h01);
    @(negedge clk);
    PI[8] = 1'b1;
    @(negedge clk);
    check("irq_lat1", 32'(IRQ_n), 32'h1);
    @(negedge clk);
    check("irq_lat2", 32'(IRQ_n), 32'h1);
    @(negedge clk);
    check("irq_lat3", 32'(IRQ_n), 32'h0);
    bus_read(1, 3, rdata, roe);
    check("ifr1_set", 32'(rdata), 32'h01);
    PI[8] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(1, 3, rdata, roe);
    check("ifr1_fall", 32'(rdata), 32'h01);
    bus_write(1, 3, 8'h01);
    check("irq_clr", 32'(IRQ_n), 32'h1);
    bus_read(1, 3, rdata, roe);
    check("ifr1_clr", 32'(rdata), 32'h00);

    // same-cycle event and write-1-clear on port 0 bit 3
    bus_write(0, 4, 8'h08);
    @(negedge clk);
    PI[3] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(0, 3, rdata, roe);
    check("ifr0_nofall", 32'(rdata), 32'h00);
    @(negedge clk);
    PI[3] = 1'b1;                       // before edge k
    @(negedge clk);                     // after k
    @(negedge clk);                     // after k+1; clear lands on k+2
    enable = 1'b1; we_n = 1'b0; A = AW'(3); DI = 8'h08;
    @(negedge clk);
    enable = 1'b0; we_n = 1'b1;
    bus_read(0, 3, rdata, roe);
    check("ifr0_setwins", 32'(rdata), 32'h08);
    bus_write(0, 3, 8'h08);
    bus_read(0, 3, rdata, roe);
    check("ifr0_clr", 32'(rdata), 32'h00);

    // reserved and out-of-range addresses
    for (int r = 5; r <= 7; r++) begin
      bus_read(0, r, rdata, roe);
      check($sformatf("rsv%0d_do", r), 32'(rdata), 32'h0);
      check($sformatf("rsv%0d_oe", r), 32'(roe), 32'h1);
    end
    bus_read(NP, 1, rdata, roe);
    check("oor_do", 32'(rdata), 32'h0);
    check("oor_oe", 32'(roe), 32'h0);
    bus_write(NP, 0, 8'hFF);
    bus_write(NP, 1, 8'hFF);
    check("oor_po",  32'(PO), 32'h0000A5);
    check("oor_ddr", 32'(DDR), 32'h0000F0);

    // asynchronous reset while a flag is pending
    @(negedge clk);
    PI[8] = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_irq", 32'(IRQ_n), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_po",  32'(PO), 32'h0);
    check("arst_ddr", 32'(DDR), 32'h0);
    check("arst_irq", 32'(IRQ_n), 32'h1);
    check("arst_oe",  32'(OE), 32'h0);

    // pins held high through reset: arm counter must block spurious flags
    PI = '1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1; we_n = 1'b0; A = AW'(4); DI = 8'hFF;   // EDGE0 = rising
    @(negedge clk);
    enable = 1'b0; we_n = 1'b1;
    for (int p = 0; p < NP; p++) bus_write(p, 2, 8'hFF);
    repeat (6) @(negedge clk);
    check("arm_irq", 32'(IRQ_n), 32'h1);
    bus_read(0, 3, rdata, roe);
    check("arm_ifr0", 32'(rdata), 32'h00);
    bus_read(0, 0, rdata, roe);
    check("arm_data0", 32'(rdata), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
